drum_sequencer: RTL and testbench

Pattern store and step player driven by the 2-bit system mode from the mode controller. It consumes `mode` and turns it into drum trigger pulses.
- EDIT: toggles pattern cells at a track/step cursor.
- PLAY: steps through the pattern at a fixed tick rate.
- RAW: passes live pad hits straight through as triggers.
Triggers feed the sound/LED back end.

---
 rtl/drumbit_pkg.sv | 16 +
 rtl/drum_sequencer_step_timer.sv | 33 +++
 rtl/drum_sequencer.sv | 106 ++++++++++
 tb/tb_drum_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/drumbit_pkg.sv
// Shared definitions for the drum sequencer and the mode controller.
//   sysmode_t      : 2-bit system mode. EDIT is 0, PLAY is 1, RAW is 2. Value 3 is decoded as EDIT.
//   DEF_NUM_TRACKS : default number of drum voices.
//   DEF_NUM_STEPS  : default pattern length.
package drumbit_pkg;

  typedef enum logic [1:0] {
    EDIT = 2'd0,
    PLAY = 2'd1,
    RAW  = 2'd2
  } sysmode_t;

  localparam int unsigned DEF_NUM_TRACKS = 4;
  localparam int unsigned DEF_NUM_STEPS  = 16;

endpackage

// File: rtl/drum_sequencer_step_timer.sv
// Step-rate divider for PLAY mode.
//   clk, rst : clock and synchronous active-high reset.
//   clear    : forces the count to 0. It takes priority over en.
//   en       : advances the count by one each cycle.
//   tick_c   : combinational pulse while enabled at terminal count (TICK_DIV-1).
module step_timer #(
  parameter int unsigned TICK_DIV = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt;

  assign tick_c = en && (tick_cnt == CNT_MAX);

  // Count wraps at terminal count so issues are exactly TICK_DIV cycles apart.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tick_cnt <= '0;
    end else if (en) begin
      if (tick_cnt == CNT_MAX) tick_cnt <= '0;
      else                     tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/drum_sequencer.sv
// Pattern store and step player.
//   EDIT (mode 0 or 3) : toggles the pattern cell at the cursor.
//   PLAY (mode 1)      : steps through the pattern at the tick rate.
//   RAW  (mode 2)      : passes rising edges of the pads through as triggers.
// Ports:
//   clk, rst             : clock and synchronous active-high reset.
//   mode                 : system mode.
//   edit_track/edit_step : cursor.
//   edit_toggle          : invert the cell at the cursor. Acts in EDIT only.
//   pads                 : live pad levels, already synchronised to clk.
//   trig                 : registered one-cycle trigger pulses, one per voice.
//   step                 : current play step.
//   beat                 : one-cycle pulse for each step issued.
//   cursor_bit           : registered pattern value at the cursor.
module drum_sequencer
  import drumbit_pkg::*;
#(
  parameter int unsigned NUM_TRACKS = DEF_NUM_TRACKS,
  parameter int unsigned NUM_STEPS  = DEF_NUM_STEPS,
  parameter int unsigned TICK_DIV   = 12500000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic [$clog2(NUM_TRACKS)-1:0] edit_track,
  input  logic [$clog2(NUM_STEPS)-1:0]  edit_step,
  input  logic                         edit_toggle,
  input  logic [NUM_TRACKS-1:0]        pads,
  output logic [NUM_TRACKS-1:0]        trig,
  output logic [$clog2(NUM_STEPS)-1:0]  step,
  output logic                         beat,
  output logic                         cursor_bit
);

  localparam int unsigned STEP_W = $clog2(NUM_STEPS);

  logic [NUM_TRACKS-1:0][NUM_STEPS-1:0] pattern, pattern_d;
  logic [NUM_TRACKS-1:0] trig_d, pad_prev, col_c;
  logic [STEP_W-1:0]     step_d, idx_c;
  logic                  beat_d, cursor_d;
  logic [1:0]            mode_prev;
  logic                  is_play_c, is_raw_c, play_entry_c, track_ok_c, tick_c;

  assign is_play_c    = (mode == PLAY);
  assign is_raw_c     = (mode == RAW);
  assign play_entry_c = is_play_c && (mode_prev != PLAY);
  // Guards non-power-of-2 track counts, where the cursor can point past the last row.
  assign track_ok_c   = (32'(edit_track) < NUM_TRACKS);

  step_timer #(.TICK_DIV(TICK_DIV)) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!is_play_c || play_entry_c),
    .en     (is_play_c && !play_entry_c),
    .tick_c (tick_c)
  );

  // Pattern column for the step about to be issued.
  assign idx_c = play_entry_c ? '0 : STEP_W'(step + 1'b1);
  always_comb begin
    col_c = '0;
    for (int t = 0; t < int'(NUM_TRACKS); t++) col_c[t] = pattern[t][idx_c];
  end

  // Next-state and output logic.
  always_comb begin
    pattern_d = pattern;
    trig_d    = '0;
    beat_d    = 1'b0;
    step_d    = step;
    cursor_d  = track_ok_c ? pattern[edit_track][edit_step] : 1'b0;
    if (is_play_c) begin
      if (play_entry_c || tick_c) begin
        step_d = idx_c;
        trig_d = col_c;
        beat_d = 1'b1;
      end
    end else if (is_raw_c) begin
      trig_d = pads & ~pad_prev;
    end else if (edit_toggle && track_ok_c) begin
      pattern_d[edit_track][edit_step] = ~pattern[edit_track][edit_step];
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern    <= '0;
      step       <= '0;
      trig       <= '0;
      beat       <= 1'b0;
      cursor_bit <= 1'b0;
      pad_prev   <= '0;
      mode_prev  <= EDIT;
    end else begin
      pattern    <= pattern_d;
      step       <= step_d;
      trig       <= trig_d;
      beat       <= beat_d;
      cursor_bit <= cursor_d;
      pad_prev   <= pads;
      mode_prev  <= mode;
    end
  end

endmodule

// File: tb/tb_drum_sequencer.sv
// Directed self-checking bench for drum_sequencer with TICK_DIV=4, 4 tracks and 16 steps.
module tb_drum_sequencer;
  import drumbit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [1:0] edit_track;
  logic [3:0] edit_step;
  logic       edit_toggle;
  logic [3:0] pads;
  logic [3:0] trig;
  logic [3:0] step;
  logic       beat;
  logic       cursor_bit;

  int n_chk = 0;
  int n_bad = 0;

  drum_sequencer #(.NUM_TRACKS(4), .NUM_STEPS(16), .TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .edit_track(edit_track), .edit_step(edit_step),
    .edit_toggle(edit_toggle), .pads(pads), .trig(trig), .step(step), .beat(beat),
    .cursor_bit(cursor_bit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse edit_toggle at a cursor, then wait for cursor_bit to show the new value.
  task automatic toggle_at(input logic [1:0] tr, input logic [3:0] st, input logic exp_bit,
                           input string tag);
    edit_track  = tr;
    edit_step   = st;
    edit_toggle = 1'b1;
    cyc(1);
    edit_toggle = 1'b0;
    chk({tag, "_lat1"}, 32'(cursor_bit), 32'(!exp_bit));
    cyc(1);
    chk(tag, 32'(cursor_bit), 32'(exp_bit));
  endtask

  initial begin
    rst = 1'b1; mode = EDIT; edit_track = '0; edit_step = '0; edit_toggle = 1'b0; pads = '0;
    cyc(2);
    chk("rst_trig", 32'(trig), 32'h0);
    chk("rst_beat", 32'(beat), 32'h0);
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_cursor", 32'(cursor_bit), 32'h0);
    rst = 1'b0;
    cyc(1);

    // Test 1: edit toggles.
    toggle_at(2'd1, 4'd0, 1'b1, "t1_1_0");
    toggle_at(2'd0, 4'd1, 1'b1, "t1_0_1");
    toggle_at(2'd3, 4'd15, 1'b1, "t1_3_15");
    toggle_at(2'd1, 4'd0, 1'b0, "t1_1_0_off");
    toggle_at(2'd1, 4'd0, 1'b1, "t1_1_0_on");
    chk("t1_edit_trig", 32'(trig), 32'h0);

    // Test 2: playback.
    mode = PLAY;
    cyc(1);
    chk("t2_entry_trig", 32'(trig), 32'h2);
    chk("t2_entry_beat", 32'(beat), 32'h1);
    chk("t2_entry_step", 32'(step), 32'h0);
    cyc(1);
    chk("t2_gap_trig", 32'(trig), 32'h0);
    chk("t2_gap_beat", 32'(beat), 32'h0);
    cyc(3);
    chk("t2_s1_trig", 32'(trig), 32'h1);
    chk("t2_s1_step", 32'(step), 32'h1);
    chk("t2_s1_beat", 32'(beat), 32'h1);
    cyc(4);
    chk("t2_s2_trig", 32'(trig), 32'h0);
    chk("t2_s2_step", 32'(step), 32'h2);
    chk("t2_s2_beat", 32'(beat), 32'h1);
    cyc(52);
    chk("t2_s15_trig", 32'(trig), 32'h8);
    chk("t2_s15_step", 32'(step), 32'hf);
    cyc(4);
    chk("t2_wrap_trig", 32'(trig), 32'h2);
    chk("t2_wrap_step", 32'(step), 32'h0);

    // Test 3: leave and re-enter PLAY; toggles ignored while playing.
    cyc(20);
    chk("t3_s5_step", 32'(step), 32'h5);
    edit_track = 2'd1; edit_step = 4'd0; edit_toggle = 1'b1;
    cyc(1);
    edit_toggle = 1'b0;
    cyc(1);
    chk("t3_play_toggle_ign", 32'(cursor_bit), 32'h1);
    mode = EDIT;
    cyc(1);
    chk("t3_edit_step_hold", 32'(step), 32'h5);
    chk("t3_edit_trig", 32'(trig), 32'h0);
    cyc(3);
    chk("t3_edit_step_hold2", 32'(step), 32'h5);
    mode = PLAY;
    cyc(1);
    chk("t3_reentry_step", 32'(step), 32'h0);
    chk("t3_reentry_trig", 32'(trig), 32'h2);
    chk("t3_reentry_beat", 32'(beat), 32'h1);

    // Test 4: RAW pad edges.
    mode = RAW;
    cyc(2);
    pads = 4'b0101;
    cyc(1);
    chk("t4_raw_edge", 32'(trig), 32'h5);
    chk("t4_raw_beat", 32'(beat), 32'h0);
    cyc(1);
    chk("t4_raw_held1", 32'(trig), 32'h0);
    cyc(1);
    chk("t4_raw_held2", 32'(trig), 32'h0);
    chk("t4_raw_step", 32'(step), 32'h0);
    pads = 4'b0000;
    mode = EDIT;
    cyc(1);
    pads = 4'b0010;
    cyc(2);
    mode = RAW;
    cyc(1);
    chk("t4_held_entry1", 32'(trig), 32'h0);
    cyc(1);
    chk("t4_held_entry2", 32'(trig), 32'h0);
    pads = 4'b0000;

    // Test 5: reset in the middle of PLAY.
    mode = PLAY;
    cyc(1);
    chk("t5_entry_step", 32'(step), 32'h0);
    cyc(28);
    chk("t5_s7_step", 32'(step), 32'h7);
    rst = 1'b1;
    cyc(1);
    chk("t5_rst_step", 32'(step), 32'h0);
    chk("t5_rst_trig", 32'(trig), 32'h0);
    chk("t5_rst_beat", 32'(beat), 32'h0);
    rst = 1'b0;
    cyc(1);
    chk("t5_post_entry_beat", 32'(beat), 32'h1);
    chk("t5_post_entry_trig", 32'(trig), 32'h0);
    mode = EDIT;
    edit_track = 2'd1; edit_step = 4'd0;
    cyc(2);
    chk("t5_clr_1_0", 32'(cursor_bit), 32'h0);
    edit_track = 2'd3; edit_step = 4'd15;
    cyc(1);
    chk("t5_clr_3_15", 32'(cursor_bit), 32'h0);
    edit_track = 2'd0; edit_step = 4'd1;
    cyc(1);
    chk("t5_clr_0_1", 32'(cursor_bit), 32'h0);

    // Test 6: mode 3 decodes as EDIT.
    mode = 2'd3;
    toggle_at(2'd2, 4'd4, 1'b1, "t6_m3_toggle");
    chk("t6_m3_trig", 32'(trig), 32'h0);
    chk("t6_m3_beat", 32'(beat), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
